// File: rtl/multi_nb_sinal.sv
// Sequential shift-add multiplier with run-time signed/unsigned mode and early exit.
// Operates on operand magnitudes; the sign is applied once at the end.
module multi_nb_sinal #(
  parameter int WA = 16,
  parameter int WB = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic             sinal,
  input  logic [WA-1:0]    multiplicando,
  input  logic [WB-1:0]    multiplicador,
  output logic [WA+WB-1:0] produto,
  output logic             estouro,
  output logic             fim,
  output logic             ocupado
);
  localparam int WP = WA + WB;

  typedef enum logic [1:0] {IDLE, CALC, AJUSTE, DONE} state_t;

  state_t          st;
  logic [WP-1:0]   mcand, acc;
  logic [WB-1:0]   mult;
  logic            neg, sinal_q;

  logic [WA-1:0]   abs_a;
  logic [WB-1:0]   abs_b;
  logic [WP-1:0]   res;
  logic [WB:0]     top_s;
  logic            ovf;

  // Most negative operand negates to itself, which reads correctly as unsigned 2^(W-1).
  always_comb begin
    abs_a = (sinal && multiplicando[WA-1]) ? -multiplicando : multiplicando;
    abs_b = (sinal && multiplicador[WB-1]) ? -multiplicador : multiplicador;
    res   = neg ? -acc : acc;
    top_s = res[WP-1:WA-1];
    if (sinal_q) ovf = !((top_s == '0) || (top_s == '1));
    else         ovf = (res[WP-1:WA] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st      <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mult    <= '0;
      neg     <= 1'b0;
      sinal_q <= 1'b0;
      produto <= '0;
      estouro <= 1'b0;
      fim     <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      case (st)
        IDLE, DONE: begin
          if (inicio) begin
            sinal_q <= sinal;
            mcand   <= {{WB{1'b0}}, abs_a};
            mult    <= abs_b;
            neg     <= sinal & (multiplicando[WA-1] ^ multiplicador[WB-1]);
            acc     <= '0;
            fim     <= 1'b0;
            ocupado <= 1'b1;
            st      <= CALC;
          end
        end
        CALC: begin
          if (mult == '0) begin
            st <= AJUSTE;
          end else begin
            if (mult[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mult  <= mult >> 1;
          end
        end
        AJUSTE: begin
          produto <= res;
          estouro <= ovf;
          fim     <= 1'b1;
          ocupado <= 1'b0;
          st      <= DONE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_nb_sinal.sv
// Randomized and directed bench for multi_nb_sinal against an arithmetic reference model.
module tb_multi_nb_sinal;
  localparam int WA = 16;
  localparam int WB = 8;
  localparam int WP = WA + WB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inicio = 1'b0;
  logic          sinal = 1'b0;
  logic [WA-1:0] multiplicando = '0;
  logic [WB-1:0] multiplicador = '0;
  logic [WP-1:0] produto;
  logic          estouro, fim, ocupado;

  int checks = 0;
  int errors = 0;

  multi_nb_sinal #(.WA(WA), .WB(WB)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .sinal(sinal),
    .multiplicando(multiplicando), .multiplicador(multiplicador),
    .produto(produto), .estouro(estouro), .fim(fim), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Reference model: true integer product of the interpreted operands.
  function automatic logic [WP-1:0] m_prod(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic s);
    longint va, vb, p;
    va = s ? longint'($signed(a)) : longint'(a);
    vb = s ? longint'($signed(b)) : longint'(b);
    p = va * vb;
    return p[WP-1:0];
  endfunction

  function automatic logic m_ovf(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic s);
    longint va, vb, p;
    va = s ? longint'($signed(a)) : longint'(a);
    vb = s ? longint'($signed(b)) : longint'(b);
    p = va * vb;
    if (s) return (p < -(64'sd1 <<< (WA-1))) || (p >= (64'sd1 <<< (WA-1)));
    return p >= (64'sd1 <<< WA);
  endfunction

  function automatic int m_lat(input logic [WB-1:0] b, input logic s);
    longint vb;
    int k;
    vb = s ? longint'($signed(b)) : longint'(b);
    if (vb < 0) vb = -vb;
    k = 0;
    while (vb > 0) begin k++; vb = vb / 2; end
    return k + 2;
  endfunction

  // Stimulus only: issue one operation from IDLE/DONE and return cycles to fim (-1 on timeout).
  task automatic run_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic s, output int lat);
    multiplicando = a; multiplicador = b; sinal = s; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    lat = -1;
    for (int i = 1; i <= WB + 6; i++) begin
      @(posedge clk); #1;
      if (fim) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({produto, estouro, fim, ocupado} !== '0) begin
      errors++;
      $display("FAIL reset: produto=%h estouro=%b fim=%b ocupado=%b, required all zero", produto, estouro, fim, ocupado);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    multiplicando = 16'd25; multiplicador = 8'd12; sinal = 1'b0; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ocupado !== 1'b1 || fim !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy cycle %0d: ocupado=%b fim=%b, required 1/0", i, ocupado, fim);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (fim !== 1'b1 || ocupado !== 1'b0 || produto !== 24'h00012C || estouro !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: fim=%b ocupado=%b produto=%h estouro=%b, required 1/0/00012c/0", fim, ocupado, produto, estouro);
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      checks++;
      if (fim !== 1'b1 || produto !== 24'h00012C) begin
        errors++;
        $display("FAIL basic_hold cycle %0d: fim=%b produto=%h, required 1/00012c", i, fim, produto);
      end
    end
  endtask

  task automatic test_directed();
    logic [WA-1:0] ta [6] = '{16'd10, 16'hFFFF, 16'hFFFD, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [WB-1:0] tb [6] = '{8'd12, 8'hFF, 8'd5, 8'h80, 8'h80, 8'h7F};
    logic          ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], ts[i], lat);
      checks++;
      if (produto !== m_prod(ta[i], tb[i], ts[i]) || estouro !== m_ovf(ta[i], tb[i], ts[i]) ||
          lat !== m_lat(tb[i], ts[i])) begin
        errors++;
        $display("FAIL directed %0d: produto=%h estouro=%b lat=%0d, required %h/%b/%0d", i, produto, estouro, lat,
                 m_prod(ta[i], tb[i], ts[i]), m_ovf(ta[i], tb[i], ts[i]), m_lat(tb[i], ts[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int s = 0; s < 2; s++) begin
      run_op(16'h1234, 8'd0, s[0], lat);
      checks++;
      if (produto !== '0 || estouro !== 1'b0 || lat !== 2) begin
        errors++;
        $display("FAIL zero_b sinal=%0d: produto=%h estouro=%b lat=%0d, required 0/0/2", s, produto, estouro, lat);
      end
      multiplicando = 16'd3; multiplicador = 8'd3; sinal = 1'b0; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      checks++;
      if (fim !== 1'b0 || produto !== '0) begin
        errors++;
        $display("FAIL b2b_accept: fim=%b produto=%h, required 0/000000", fim, produto);
      end
      lat = -1;
      for (int i = 1; i <= WB + 6; i++) begin
        @(posedge clk); #1;
        if (fim) begin lat = i; break; end
      end
      checks++;
      if (produto !== 24'd9 || lat !== 4) begin
        errors++;
        $display("FAIL b2b_result: produto=%h lat=%0d, required 000009/4", produto, lat);
      end
    end
  endtask

  task automatic test_ignore();
    int lat;
    multiplicando = 16'd25; multiplicador = 8'd12; sinal = 1'b0; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    @(posedge clk); #1;
    multiplicando = 16'd1; multiplicador = 8'd1; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0; multiplicando = 16'($urandom); multiplicador = 8'($urandom); sinal = 1'b1;
    lat = -1;
    for (int i = 3; i <= WB + 6; i++) begin
      @(posedge clk); #1;
      if (fim) begin lat = i; break; end
    end
    checks++;
    if (produto !== 24'd300 || lat !== 6 || estouro !== 1'b0) begin
      errors++;
      $display("FAIL ignore_inicio: produto=%h lat=%0d estouro=%b, required 00012c/6/0", produto, lat, estouro);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    multiplicando = 16'hFFFF; multiplicador = 8'hFF; sinal = 1'b0; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if (produto !== '0 || fim !== 1'b0 || ocupado !== 1'b0 || estouro !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: produto=%h fim=%b ocupado=%b estouro=%b, required all zero", produto, fim, ocupado, estouro);
    end
    run_op(16'd7, 8'd6, 1'b0, lat);
    checks++;
    if (produto !== 24'd42 || estouro !== 1'b0 || lat !== 5) begin
      errors++;
      $display("FAIL after_abort: produto=%h estouro=%b lat=%0d, required 00002a/0/5", produto, estouro, lat);
    end
  endtask

  task automatic test_random();
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic s;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      if (i % 10 == 0) b = 8'($urandom_range(0, 3));
      run_op(a, b, s, lat);
      checks++;
      if (produto !== m_prod(a, b, s) || estouro !== m_ovf(a, b, s) || lat !== m_lat(b, s)) begin
        errors++;
        $display("FAIL random a=%h b=%h s=%b: produto=%h estouro=%b lat=%0d, required %h/%b/%0d", a, b, s,
                 produto, estouro, lat, m_prod(a, b, s), m_ovf(a, b, s), m_lat(b, s));
      end
      if (i % 3 == 0) repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_nb_sinal.md
Name: multi_nb_sinal

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 16x8 multiplier in the ULA multiplier/divider datapath.
- Supports independent operand widths and a run-time signed/unsigned mode.
- Returns the full-width product plus an overflow flag for the legacy WA-bit result path.
- Terminates early once the remaining multiplier bits are zero.
- Uses the inicio/fim start/done handshake, plus a busy flag.

Parameters:
WA, 16, multiplicando width (>=2)
WB, 8, multiplicador width (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, active-low, synchronous
inicio  input  1  start request, sampled on rising edge
sinal  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands
multiplicando  input  WA  operand A, latched on accepted inicio
multiplicador  input  WB  operand B, latched on accepted inicio
produto  output  WA+WB  full product (two's complement when sinal=1)
estouro  output  1  product not representable in WA bits (unsigned or signed per mode)
fim  output  1  result valid, held high until next accepted inicio or reset
ocupado  output  1  operation in progress

Behaviour:
- Reset (rst=0 at rising edge):
  - state IDLE; produto=0, estouro=0, fim=0, ocupado=0.
  - All internal registers cleared; any in-flight operation is abandoned.
  - rst has priority over inicio.
- States: IDLE, CALC, AJUSTE, DONE.
- Start acceptance:
  - inicio is accepted only in IDLE or DONE.
  - In CALC/AJUSTE, inicio is ignored (not queued).
- Accepting edge (edge 0):
  - Latch sinal.
  - mcand = |A| zero-extended to WA+WB bits; mult = |B| as WB-bit unsigned.
  - Latch neg = sinal & (A[WA-1] ^ B[WB-1]).
  - Accumulator acc = 0; fim=0; ocupado=1; state -> CALC.
- Absolute value: taken only when sinal=1. The most negative value maps to 2^(W-1), which is representable unsigned in W bits.
- CALC, each edge:
  - If mult == 0: state -> AJUSTE; no arithmetic.
  - Else:
    - if mult[0]: acc += mcand (modulo 2^(WA+WB); cannot overflow);
    - mcand <<= 1; mult >>= 1.
- AJUSTE, one edge:
  - produto = neg ? -acc : acc (two's complement, WA+WB bits).
  - estouro:
    - sinal=0: set when produto[WA+WB-1:WA] != 0.
    - sinal=1: set when produto[WA+WB-1:WA-1] is not all-zeros or all-ones.
  - fim=1; ocupado=0; state -> DONE.
- Latency:
  - k = bit length of |B| (index of highest set bit + 1; k=0 for B=0).
  - fim rises on edge k+2 after the accepting edge.
  - Minimum 2 cycles, maximum WB+2.
- Result stability:
  - produto/estouro are stable from fim rise until the AJUSTE edge of the next operation.
  - A new accepted inicio clears fim but leaves produto unchanged until that AJUSTE.
- DONE:
  - Holds fim=1 indefinitely.
  - inicio=1 in DONE behaves exactly as in IDLE; back-to-back operations need no idle cycle.
- Operand changes: changes to operand inputs after the accepting edge have no effect on the running operation.
- Reset mid-operation:
  - Outputs return to reset values on that edge.
  - The next inicio starts a fresh operation.

Test Plan:
- WA=16, WB=8, sinal=0, A=25, B=12, pulse inicio -> fim rises 6 cycles after accepting edge, produto=300 (0x00012C), estouro=0, ocupado high for cycles 1-5; fim stays high for 100 further cycles.
- Reset, then A=10, B=12, sinal=0 -> produto=120, fim after 6 cycles. Separately: A=0xFFFF, B=0xFF -> produto=0xFEFF01, estouro=1, fim after 10 cycles.
- sinal=1, A=0xFFFD (-3), B=5 -> produto=0xFFFFF1, estouro=0. Also: A=0xFFFF (-1), B=0x80 (-128) -> produto=0x000080, estouro=0, latency 10.
- B=0, A=0x1234, either mode -> produto=0, estouro=0, fim exactly 2 cycles after accept. Then, with fim still high, inicio with A=3, B=3 -> fim drops next edge, produto=9 four cycles after accept.
- Start A=25, B=12. Re-assert inicio with A=1, B=1 on cycle 2 -> ignored; result still 300 at cycle 6. Change operand inputs during CALC -> no effect on result.
- Start A=0xFFFF, B=0xFF. Drive rst=0 for one edge at cycle 3 -> produto=0, fim=0, ocupado=0 next edge. Then a new start with A=7, B=6 -> produto=42, no residue from the aborted operation.
